// File: rtl/handshake_fifo_buffer.sv
// Opaque valid/ready FIFO with DEPTH slots and a registered occupancy count.
// Both handshake outputs come from flops, so there is no comb path from in to out.
module handshake_fifo_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        ins,
    input  logic                         ins_valid,
    output logic                         ins_ready,
    output logic [DATA_WIDTH-1:0]        outs,
    output logic                         outs_valid,
    input  logic                         outs_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ins_ready_q, ins_ready_d;
    logic                  outs_valid_q, outs_valid_d;
    logic                  push, pop;

    assign push = ins_valid & ins_ready_q;
    assign pop  = outs_valid_q & outs_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Flags are precomputed from the next count so they stay pure flop outputs.
    always_comb begin
        ins_ready_d  = (count_d != FULL);
        outs_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ins_ready_q  <= 1'b1;
            outs_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ins_ready_q  <= ins_ready_d;
            outs_valid_q <= outs_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ins;
        end
    end

    assign ins_ready  = ins_ready_q;
    assign outs_valid = outs_valid_q;
    assign outs       = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Scoreboard bench for handshake_fifo_buffer at DEPTH 4, 3 and 5.
// Inputs change on falling edges; outputs are sampled 1ns later.
module tb_handshake_fifo_buffer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // DEPTH=4 instance
    logic [7:0] ins4, outs4;
    logic       iv4 = 0, ir4, ov4, or4 = 0;
    logic [2:0] cnt4;
    // DEPTH=3 instance
    logic [7:0] ins3, outs3;
    logic       iv3 = 0, ir3, ov3, or3 = 0;
    logic [1:0] cnt3;
    // DEPTH=5 instance
    logic [7:0] ins5, outs5;
    logic       iv5 = 0, ir5, ov5, or5 = 0;
    logic [2:0] cnt5;

    logic [7:0] sb4[$];
    logic [7:0] sb3[$];
    logic [7:0] sb5[$];

    handshake_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .ins(ins4), .ins_valid(iv4), .ins_ready(ir4),
        .outs(outs4), .outs_valid(ov4), .outs_ready(or4), .count(cnt4));
    handshake_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(3)) u3 (
        .clk(clk), .rst(rst), .ins(ins3), .ins_valid(iv3), .ins_ready(ir3),
        .outs(outs3), .outs_valid(ov3), .outs_ready(or3), .count(cnt3));
    handshake_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(5)) u5 (
        .clk(clk), .rst(rst), .ins(ins5), .ins_valid(iv5), .ins_ready(ir5),
        .outs(outs5), .outs_valid(ov5), .outs_ready(or5), .count(cnt5));

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (cnt4 !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", cnt4); end
        n_vec++;
        if (ov4 !== 1'b0) begin n_err++; $display("FAIL reset_outs_valid got %b want 0", ov4); end
        n_vec++;
        if (ir4 !== 1'b1) begin n_err++; $display("FAIL reset_ins_ready got %b want 1", ir4); end
        n_vec++;
        if (cnt5 !== 3'd0 || ir3 !== 1'b1) begin
            n_err++; $display("FAIL reset_others got cnt5=%0d ir3=%b want 0/1", cnt5, ir3);
        end
        @(negedge clk);
        rst = 1'b0;
        sb4.delete(); sb3.delete(); sb5.delete();
    endtask

    task automatic test_latency();
        logic [7:0] exp;
        @(negedge clk);
        ins4 = 8'hA1; iv4 = 1; or4 = 1;
        #1;
        n_vec++;
        if (ov4 !== 1'b0) begin n_err++; $display("FAIL lat_c0_valid got %b want 0", ov4); end
        sb4.push_back(8'hA1);
        @(negedge clk);
        iv4 = 0;
        #1;
        n_vec++;
        if (ov4 !== 1'b1) begin n_err++; $display("FAIL lat_c1_valid got %b want 1", ov4); end
        exp = sb4.pop_front();
        n_vec++;
        if (outs4 !== exp) begin n_err++; $display("FAIL lat_c1_data got %h want %h", outs4, exp); end
        @(negedge clk);
        #1;
        n_vec++;
        if (cnt4 !== 3'd0 || ov4 !== 1'b0) begin
            n_err++; $display("FAIL lat_c2_empty got cnt=%0d ov=%b want 0/0", cnt4, ov4);
        end
        or4 = 0;
    endtask

    task automatic test_fill();
        logic [7:0] exp;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            or4 = 0; iv4 = 1; ins4 = 8'(i);
            sb4.push_back(8'(i));
        end
        @(negedge clk);
        ins4 = 8'hEE;
        #1;
        n_vec++;
        if (cnt4 !== 3'd4) begin n_err++; $display("FAIL fill_count got %0d want 4", cnt4); end
        n_vec++;
        if (ir4 !== 1'b0) begin n_err++; $display("FAIL fill_ready got %b want 0", ir4); end
        @(negedge clk);
        @(negedge clk);
        iv4 = 0;
        #1;
        n_vec++;
        if (cnt4 !== 3'd4) begin n_err++; $display("FAIL fill_ignore got %0d want 4", cnt4); end
        for (int i = 0; i < 8 && sb4.size() > 0; i++) begin
            @(negedge clk);
            or4 = 1;
            #1;
            exp = sb4.pop_front();
            n_vec++;
            if (ov4 !== 1'b1 || outs4 !== exp) begin
                n_err++; $display("FAIL fill_drain got %h/%b want %h/1", outs4, ov4, exp);
            end
        end
        @(negedge clk);
        or4 = 0;
        #1;
        n_vec++;
        if (cnt4 !== 3'd0) begin n_err++; $display("FAIL fill_empty got %0d want 0", cnt4); end
    endtask

    task automatic test_full_simul();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            or4 = 0; iv4 = 1; ins4 = 8'h10 + 8'(i);
            sb4.push_back(8'h10 + 8'(i));
        end
        @(negedge clk);
        iv4 = 1; ins4 = 8'h20; or4 = 1;
        #1;
        n_vec++;
        if (ir4 !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", ir4); end
        exp = sb4.pop_front();
        n_vec++;
        if (outs4 !== exp) begin n_err++; $display("FAIL full_head got %h want %h", outs4, exp); end
        @(negedge clk);
        or4 = 0;
        #1;
        n_vec++;
        if (cnt4 !== 3'd3 || ir4 !== 1'b1) begin
            n_err++; $display("FAIL full_pop_only got cnt=%0d ir=%b want 3/1", cnt4, ir4);
        end
        sb4.push_back(8'h20);
        @(negedge clk);
        iv4 = 0;
        #1;
        n_vec++;
        if (cnt4 !== 3'd4) begin n_err++; $display("FAIL full_accept got %0d want 4", cnt4); end
        for (int i = 0; i < 8 && sb4.size() > 0; i++) begin
            @(negedge clk);
            or4 = 1;
            #1;
            exp = sb4.pop_front();
            n_vec++;
            if (ov4 !== 1'b1 || outs4 !== exp) begin
                n_err++; $display("FAIL full_drain got %h/%b want %h/1", outs4, ov4, exp);
            end
        end
        @(negedge clk);
        or4 = 0;
    endtask

    task automatic test_stream();
        bit pu, po;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            or3 = 1;
            iv3 = (i < 10);
            ins3 = 8'(i);
            #1;
            if (i > 0) begin
                n_vec++;
                if (ov3 !== 1'b1 || outs3 !== sb3[0]) begin
                    n_err++; $display("FAIL stream_out got %h/%b want %h/1", outs3, ov3, sb3[0]);
                end
                n_vec++;
                if (cnt3 !== 2'd1 || ir3 !== 1'b1) begin
                    n_err++; $display("FAIL stream_count got %0d/%b want 1/1", cnt3, ir3);
                end
            end
            pu = iv3 && sb3.size() != 3;
            po = or3 && sb3.size() != 0;
            @(posedge clk);
            if (po) void'(sb3.pop_front());
            if (pu) sb3.push_back(ins3);
        end
        @(negedge clk);
        iv3 = 0; or3 = 0;
        #1;
        n_vec++;
        if (cnt3 !== 2'd0 || sb3.size() != 0) begin
            n_err++; $display("FAIL stream_end got %0d want 0", cnt3);
        end
    endtask

    task automatic test_random();
        bit pu, po;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            iv5 = 1'($urandom_range(0, 1));
            or5 = 1'($urandom_range(0, 1));
            ins5 = 8'($urandom);
            #1;
            n_vec++;
            if (int'(cnt5) != sb5.size() || ov5 !== (sb5.size() != 0)
                || ir5 !== (sb5.size() != 5)) begin
                n_err++;
                $display("FAIL rand_state cyc %0d got cnt=%0d ov=%b ir=%b want cnt=%0d",
                         c, cnt5, ov5, ir5, sb5.size());
            end
            if (sb5.size() != 0) begin
                n_vec++;
                if (outs5 !== sb5[0]) begin
                    n_err++; $display("FAIL rand_data cyc %0d got %h want %h", c, outs5, sb5[0]);
                end
            end
            pu = iv5 && sb5.size() != 5;
            po = or5 && sb5.size() != 0;
            @(posedge clk);
            if (po) void'(sb5.pop_front());
            if (pu) sb5.push_back(ins5);
        end
        @(negedge clk);
        iv5 = 0; or5 = 0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            or4 = 0; iv4 = 1; ins4 = 8'h30 + 8'(i);
        end
        @(negedge clk);
        iv4 = 0;
        #1;
        n_vec++;
        if (cnt4 !== 3'd2) begin n_err++; $display("FAIL arst_pre got %0d want 2", cnt4); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (ov4 !== 1'b0 || ir4 !== 1'b1 || cnt4 !== 3'd0) begin
            n_err++; $display("FAIL arst_now got ov=%b ir=%b cnt=%0d want 0/1/0", ov4, ir4, cnt4);
        end
        #1;
        rst = 1'b0;
        sb4.delete(); sb3.delete(); sb5.delete();
        @(negedge clk);
        iv4 = 1; ins4 = 8'h55; or4 = 1;
        sb4.push_back(8'h55);
        @(negedge clk);
        iv4 = 0;
        #1;
        n_vec++;
        if (ov4 !== 1'b1 || outs4 !== sb4[0]) begin
            n_err++; $display("FAIL arst_first got %h/%b want %h/1", outs4, ov4, sb4[0]);
        end
        void'(sb4.pop_front());
        @(negedge clk);
        or4 = 0;
        #1;
        n_vec++;
        if (cnt4 !== 3'd0) begin n_err++; $display("FAIL arst_drain got %0d want 0", cnt4); end
    endtask

    initial begin
        ins4 = '0; ins3 = '0; ins5 = '0;
        test_reset();
        test_latency();
        test_fill();
        test_full_simul();
        test_stream();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

endmodule
